// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns with match masks, ALU codes and the
// control bundle carried through the decode slot.
package legv8_pkg;

  localparam logic [10:0] MaskFull = 11'b111_1111_1111;
  localparam logic [10:0] MaskImm  = 11'b111_1111_1110;
  localparam logic [10:0] MaskCb   = 11'b111_1111_1000;
  localparam logic [10:0] MaskB    = 11'b111_1110_0000;

  localparam logic [10:0] OpAdd  = 11'b100_0101_1000;
  localparam logic [10:0] OpSub  = 11'b110_0101_1000;
  localparam logic [10:0] OpAnd  = 11'b100_0101_0000;
  localparam logic [10:0] OpOrr  = 11'b101_0101_0000;
  localparam logic [10:0] OpAddi = 11'b100_1000_1000;
  localparam logic [10:0] OpSubi = 11'b110_1000_1000;
  localparam logic [10:0] OpLdur = 11'b111_1100_0010;
  localparam logic [10:0] OpStur = 11'b111_1100_0000;
  localparam logic [10:0] OpCbz  = 11'b101_1010_0000;
  localparam logic [10:0] OpB    = 11'b000_1010_0000;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOrr   = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluPassB = 4'b0111;

  typedef struct packed {
    logic       unconditional_branch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op ^ pat) & mask) == 11'd0;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational LEGv8 opcode decoder: control bundle, register index fields and which of
// those fields the instruction actually reads.
module control_decode
  import legv8_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [31:0]      instr_i,
  output ctrl_t            ctrl_o,
  output logic [REG_W-1:0] rn_o,
  output logic [REG_W-1:0] rm_o,
  output logic [REG_W-1:0] rt_o,
  output logic [REG_W-1:0] rs2_o,
  output logic             use_rn_o,
  output logic             use_rm_o,
  output logic             use_rt_o
);

  logic [10:0] op;
  logic        rs2_is_rt;

  assign op   = instr_i[31:21];
  assign rn_o = REG_W'(instr_i[9:5]);
  assign rm_o = REG_W'(instr_i[20:16]);
  assign rt_o = REG_W'(instr_i[4:0]);
  assign rs2_o = rs2_is_rt ? rt_o : rm_o;

  always_comb begin
    ctrl_o    = '0;
    use_rn_o  = 1'b0;
    use_rm_o  = 1'b0;
    use_rt_o  = 1'b0;
    rs2_is_rt = 1'b0;
    if (op_match(op, OpAdd, MaskFull)) begin
      ctrl_o.alu_op    = AluAdd;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
      use_rm_o         = 1'b1;
    end else if (op_match(op, OpSub, MaskFull)) begin
      ctrl_o.alu_op    = AluSub;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
      use_rm_o         = 1'b1;
    end else if (op_match(op, OpAnd, MaskFull)) begin
      ctrl_o.alu_op    = AluAnd;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
      use_rm_o         = 1'b1;
    end else if (op_match(op, OpOrr, MaskFull)) begin
      ctrl_o.alu_op    = AluOrr;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
      use_rm_o         = 1'b1;
    end else if (op_match(op, OpAddi, MaskImm)) begin
      ctrl_o.alu_op    = AluAdd;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
    end else if (op_match(op, OpSubi, MaskImm)) begin
      ctrl_o.alu_op    = AluSub;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      use_rn_o         = 1'b1;
    end else if (op_match(op, OpLdur, MaskFull)) begin
      ctrl_o.alu_op     = AluAdd;
      ctrl_o.alu_src    = 1'b1;
      ctrl_o.mem_read   = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      use_rn_o          = 1'b1;
    end else if (op_match(op, OpStur, MaskFull)) begin
      ctrl_o.alu_op    = AluAdd;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.mem_write = 1'b1;
      rs2_is_rt        = 1'b1;
      use_rn_o         = 1'b1;
      use_rt_o         = 1'b1;
    end else if (op_match(op, OpCbz, MaskCb)) begin
      ctrl_o.alu_op = AluPassB;
      ctrl_o.branch = 1'b1;
      rs2_is_rt     = 1'b1;
      use_rt_o      = 1'b1;
    end else if (op_match(op, OpB, MaskB)) begin
      ctrl_o.alu_op               = AluAnd;
      ctrl_o.unconditional_branch = 1'b1;
    end else begin
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Handshaked LEGv8 decode stage: one-entry output slot, load-use bubble insertion, flush
// and a saturating count of inserted bubbles.
module decode_stage
  import legv8_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             unconditionalBranch,
  output logic             branch,
  output logic             memRead,
  output logic             memToReg,
  output logic             memWrite,
  output logic             aluSRC,
  output logic             regWriteFlag,
  output logic [3:0]       aluControlCode,
  output logic [REG_W-1:0] readRegister1,
  output logic [REG_W-1:0] readRegister2,
  output logic [REG_W-1:0] writeRegister,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_rn, dec_rm, dec_rt, dec_rs2;
  logic             use_rn, use_rm, use_rt;

  control_decode #(
    .REG_W(REG_W)
  ) u_control_decode (
    .instr_i (instruction),
    .ctrl_o  (dec_ctrl),
    .rn_o    (dec_rn),
    .rm_o    (dec_rm),
    .rt_o    (dec_rt),
    .rs2_o   (dec_rs2),
    .use_rn_o(use_rn),
    .use_rm_o(use_rm),
    .use_rt_o(use_rt)
  );

  ctrl_t            ctrl_q, ctrl_d;
  logic [REG_W-1:0] rr1_q, rr1_d, rr2_q, rr2_d, wr_q, wr_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             src_match, hazard, accept;

  // A load in the slot whose destination the incoming instruction reads must not be
  // overtaken; XZR never carries a real value so it never stalls.
  assign src_match = (use_rn && dec_rn == wr_q) || (use_rm && dec_rm == wr_q) ||
                     (use_rt && dec_rt == wr_q);
  assign hazard = in_valid && out_valid_q && ctrl_q.mem_read &&
                  (wr_q != REG_W'(ZERO_REG)) && src_match;
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    ctrl_d        = ctrl_q;
    rr1_d         = rr1_q;
    rr2_d         = rr2_q;
    wr_d          = wr_q;
    out_valid_d   = out_valid_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      ctrl_d      = dec_ctrl;
      rr1_d       = dec_rn;
      rr2_d       = dec_rs2;
      wr_d        = dec_rt;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard && out_ready && !flush && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q        <= '0;
      rr1_q         <= '0;
      rr2_q         <= '0;
      wr_q          <= '0;
      out_valid_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      rr1_q         <= rr1_d;
      rr2_q         <= rr2_d;
      wr_q          <= wr_d;
      out_valid_q   <= out_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid           = out_valid_q;
  assign unconditionalBranch = ctrl_q.unconditional_branch;
  assign branch              = ctrl_q.branch;
  assign memRead             = ctrl_q.mem_read;
  assign memToReg            = ctrl_q.mem_to_reg;
  assign memWrite            = ctrl_q.mem_write;
  assign aluSRC              = ctrl_q.alu_src;
  assign regWriteFlag        = ctrl_q.reg_write;
  assign aluControlCode      = ctrl_q.alu_op;
  assign illegal             = ctrl_q.illegal;
  assign readRegister1       = rr1_q;
  assign readRegister2       = rr2_q;
  assign writeRegister       = wr_q;
  assign stall_count         = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted instructions push hand-decoded results, a
// monitor pops and compares on every output transfer.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic        unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag;
  logic [3:0]  aluControlCode;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic        illegal;
  logic [15:0] stall_count;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock              (clock),
    .reset              (reset),
    .instruction        (instruction),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .flush              (flush),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .unconditionalBranch(unconditionalBranch),
    .branch             (branch),
    .memRead            (memRead),
    .memToReg           (memToReg),
    .memWrite           (memWrite),
    .aluSRC             (aluSRC),
    .regWriteFlag       (regWriteFlag),
    .aluControlCode     (aluControlCode),
    .readRegister1      (readRegister1),
    .readRegister2      (readRegister2),
    .writeRegister      (writeRegister),
    .illegal            (illegal),
    .stall_count        (stall_count)
  );

  // flags order: ub, br, mr, m2r, mw, src, rw
  typedef struct packed {
    logic [6:0] flags;
    logic [3:0] alu;
    logic       ill;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] wr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [6:0] f, input logic [3:0] alu, input logic ill,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr);
    exp_t e;
    e.flags = f; e.alu = alu; e.ill = ill; e.r1 = r1; e.r2 = r2; e.wr = wr;
    return e;
  endfunction

  function automatic exp_t dut_slot();
    exp_t a;
    a.flags = {unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag};
    a.alu = aluControlCode; a.ill = illegal;
    a.r1 = readRegister1; a.r2 = readRegister2; a.wr = writeRegister;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Holds the word until accepted; pushes the expected slot contents at acceptance.
  task automatic send(input logic [31:0] w, input exp_t e);
    bit accepted = 0;
    in_valid = 1'b1;
    instruction = w;
    for (int i = 0; i < 10 && !accepted; i++) begin
      #3;
      if (in_ready) begin
        sb.push_back(e);
        accepted = 1;
      end
      step();
    end
    if (!accepted) chk("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      exp_t a;
      a = dut_slot();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL slot: got unexpected output %h, expected none", a);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL slot: got %h expected %h", a, e);
        end
      end
    end
  end

  localparam logic [31:0] WAdd   = 32'h8B02_0023;
  localparam logic [31:0] WOrr   = 32'hAA09_0107;
  localparam logic [31:0] WSubi  = 32'hD100_04A4;
  localparam logic [31:0] WStur  = 32'hF800_0041;
  localparam logic [31:0] WCbz   = 32'hB400_0045;
  localparam logic [31:0] WB     = 32'h1400_0004;
  localparam logic [31:0] WLdur  = 32'hF840_0041;
  localparam logic [31:0] WLdz   = 32'hF840_005F;
  localparam logic [31:0] WAddz  = 32'h8B02_03E3;

  exp_t eadd, eorr, esubi, estur, ecbz, eb, eill, eldur, eldz, eaddz;
  time  t0;

  initial begin
    eadd  = mk(7'b0000001, 4'b0010, 1'b0, 5'd1, 5'd2, 5'd3);
    eorr  = mk(7'b0000001, 4'b0001, 1'b0, 5'd8, 5'd9, 5'd7);
    esubi = mk(7'b0000011, 4'b0110, 1'b0, 5'd5, 5'd0, 5'd4);
    estur = mk(7'b0000110, 4'b0010, 1'b0, 5'd2, 5'd1, 5'd1);
    ecbz  = mk(7'b0100000, 4'b0111, 1'b0, 5'd2, 5'd5, 5'd5);
    eb    = mk(7'b1000000, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd4);
    eill  = mk(7'b0000000, 4'b0000, 1'b1, 5'd0, 5'd0, 5'd0);
    eldur = mk(7'b0011011, 4'b0010, 1'b0, 5'd2, 5'd0, 5'd1);
    eldz  = mk(7'b0011011, 4'b0010, 1'b0, 5'd2, 5'd0, 5'd31);
    eaddz = mk(7'b0000001, 4'b0010, 1'b0, 5'd31, 5'd2, 5'd3);

    reset = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0; out_ready = 1'b1;
    #2;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset slot", 32'(dut_slot()), 32'd0);
    chk("reset stall_count", {16'd0, stall_count}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;

    // Back-to-back issue at one per cycle.
    t0 = $time;
    send(WAdd, eadd);
    send(WOrr, eorr);
    send(WSubi, esubi);
    send(WStur, estur);
    chk("throughput", 32'($time - t0), 32'd40);
    send(WCbz, ecbz);
    send(WB, eb);
    send(32'h0000_0000, eill);
    step();
    step();

    // Load-use: one bubble, dependent ADD accepted the next cycle.
    send(WLdur, eldur);
    in_valid = 1'b1;
    instruction = WAdd;
    #3;
    chk("hazard in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bubble out_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble stall_count", {16'd0, stall_count}, 32'd1);
    chk("post-bubble in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(eadd);
    step();
    in_valid = 1'b0;

    // Load to XZR never stalls.
    t0 = $time;
    send(WLdz, eldz);
    send(WAddz, eaddz);
    chk("xzr no bubble", 32'($time - t0), 32'd20);
    chk("xzr stall_count", {16'd0, stall_count}, 32'd1);
    step();

    // Flush in a hazard cycle: flush wins, nothing counted.
    send(WLdur, eldur);
    in_valid = 1'b1;
    instruction = WAdd;
    flush = 1'b1;
    #3;
    chk("flush+hazard in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush+hazard out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush+hazard stall_count", {16'd0, stall_count}, 32'd1);

    // Backpressure holds the slot; then flush discards it and refuses input.
    out_ready = 1'b0;
    send(WOrr, eorr);
    in_valid = 1'b1;
    instruction = WAdd;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall slot stable", 32'(dut_slot()), 32'(eorr));
      chk("stall out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    flush = 1'b1;
    #3;
    chk("flush in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    void'(sb.pop_back());
    in_valid = 1'b0;
    step();
    chk("flushed word not taken", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with a full slot and a nonzero counter.
    send(WSubi, esubi);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset slot", 32'(dut_slot()), 32'd0);
    chk("async reset stall_count", {16'd0, stall_count}, 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    out_ready = 1'b1;

    send(WCbz, ecbz);
    step();
    step();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
